// File: rtl/fifo_rd_word_packer.sv
// Pops entries from an async FIFO read port and packs PACK_RATIO of them (lane 0 in the LSBs) into one output word.
// Latency: the word becomes visible on the edge that pops its last entry; sustained rate is one entry per cycle.
// Backpressure: a full accumulator plus a held output word stops popping; FLUSH emits a partial word once the slot frees.
module fifo_rd_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO,
    localparam int CNT_WIDTH = $clog2(PACK_RATIO + 1)
) (
    input  logic                  R_CLK,
    input  logic                  R_RST_N,
    input  logic                  R_EMPTY,
    input  logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  R_INC_EN,
    input  logic                  FLUSH,
    input  logic                  OUT_READY,
    output logic                  OUT_VALID,
    output logic [OUT_WIDTH-1:0]  OUT_DATA,
    output logic [CNT_WIDTH-1:0]  OUT_BYTES
);

    localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(PACK_RATIO - 1);

    typedef logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes_t;

    lanes_t               lanes_q;
    lanes_t               lanes_nxt;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 flush_pend;
    logic                 slot_free;
    logic                 pop;
    logic                 complete;
    logic                 flush_req;
    logic                 load;

    assign slot_free = !OUT_VALID || OUT_READY;

    // The last lane may only be popped if the finished word can move out on the same edge.
    assign pop      = R_RST_N && !R_EMPTY && !flush_pend && !(cnt_q == LAST_LANE && !slot_free);
    assign R_INC_EN = pop;
    assign complete = pop && (cnt_q == LAST_LANE);
    assign cnt_nxt  = cnt_q + CNT_WIDTH'(pop);

    // cnt_nxt includes a coincident pop, so a FLUSH on an empty accumulator with no pop is dropped.
    assign flush_req = flush_pend || (FLUSH && (cnt_nxt != '0));
    assign load      = complete || (flush_req && slot_free);

    always_comb begin
        lanes_nxt = lanes_q;
        for (int i = 0; i < PACK_RATIO; i++) begin
            if (pop && cnt_q == CNT_WIDTH'(i)) begin
                lanes_nxt[i] = R_DATA;
            end
        end
    end

    always_ff @(posedge R_CLK) begin
        if (!R_RST_N) begin
            lanes_q    <= '0;
            cnt_q      <= '0;
            flush_pend <= 1'b0;
            OUT_VALID  <= 1'b0;
            OUT_DATA   <= '0;
            OUT_BYTES  <= '0;
        end else if (load) begin
            // Unused lanes are already zero because the accumulator is cleared on every load.
            OUT_VALID  <= 1'b1;
            OUT_DATA   <= lanes_nxt;
            OUT_BYTES  <= cnt_nxt;
            lanes_q    <= '0;
            cnt_q      <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
            lanes_q <= lanes_nxt;
            cnt_q   <= cnt_nxt;
            if (flush_req) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_word_packer.sv
// Bench for fifo_rd_word_packer: directed vector table, hand-written corner sequences and a random run against a queue model.
module tb_fifo_rd_word_packer;

    localparam int DW = 8;
    localparam int PR = 4;

    logic        R_CLK = 1'b0;
    logic        R_RST_N;
    logic        R_EMPTY;
    logic [7:0]  R_DATA;
    logic        R_INC_EN;
    logic        FLUSH;
    logic        OUT_READY;
    logic        OUT_VALID;
    logic [31:0] OUT_DATA;
    logic [2:0]  OUT_BYTES;

    fifo_rd_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .R_CLK     (R_CLK),
        .R_RST_N   (R_RST_N),
        .R_EMPTY   (R_EMPTY),
        .R_DATA    (R_DATA),
        .R_INC_EN  (R_INC_EN),
        .FLUSH     (FLUSH),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_BYTES (OUT_BYTES)
    );

    always #5 R_CLK = ~R_CLK;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    logic [7:0]  fq[$];
    logic [7:0]  m_pend[$];
    bit          m_fp;
    bit          m_vld;
    logic [31:0] m_word;
    logic [2:0]  m_bytes;
    logic [31:0] got_d[$];
    logic [2:0]  got_b[$];

    typedef struct {
        bit          rst_n;
        bit          flush;
        bit          ready;
        bit          inc;
        bit          vld;
        bit          chk_dat;
        logic [31:0] dat;
        logic [2:0]  bytes;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        R_EMPTY = (fq.size() == 0);
        R_DATA  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // One clock: compare against the queue model before the edge, advance model and FIFO after it.
    task automatic step();
        bit          inc_s;
        bit          slot_free;
        bit          exp_inc;
        bit          flush_now;
        logic [31:0] w;
        drive_fifo();
        #1;
        inc_s = R_INC_EN;
        if (R_RST_N && OUT_VALID && OUT_READY) begin
            got_d.push_back(OUT_DATA);
            got_b.push_back(OUT_BYTES);
        end
        if (!R_RST_N) begin
            chk("inc_in_reset", {31'b0, R_INC_EN}, 32'd0);
            m_pend.delete();
            m_fp    = 1'b0;
            m_vld   = 1'b0;
            m_word  = '0;
            m_bytes = '0;
        end else begin
            slot_free = !m_vld || OUT_READY;
            exp_inc   = (fq.size() != 0) && !m_fp && !(m_pend.size() == PR - 1 && !slot_free);
            chk("inc", {31'b0, R_INC_EN}, {31'b0, exp_inc});
            chk("valid", {31'b0, OUT_VALID}, {31'b0, m_vld});
            if (m_vld) begin
                chk("data", OUT_DATA, m_word);
                chk("bytes", {29'b0, OUT_BYTES}, {29'b0, m_bytes});
            end
            if (m_vld && OUT_READY) m_vld = 1'b0;
            if (exp_inc) m_pend.push_back(fq[0]);
            flush_now = m_fp || (FLUSH && m_pend.size() != 0);
            if (m_pend.size() == PR || (flush_now && slot_free)) begin
                w = '0;
                foreach (m_pend[k]) w = w | (32'(m_pend[k]) << (8 * k));
                m_word  = w;
                m_bytes = 3'(m_pend.size());
                m_vld   = 1'b1;
                m_pend.delete();
                m_fp    = 1'b0;
            end else if (flush_now) begin
                m_fp = 1'b1;
            end
        end
        @(posedge R_CLK);
        #1;
        if (inc_s) begin
            pops++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        drive_fifo();
    endtask

    task automatic do_reset();
        R_RST_N   = 1'b0;
        FLUSH     = 1'b0;
        OUT_READY = 1'b1;
        step();
        R_RST_N = 1'b1;
        fq.delete();
        got_d.delete();
        got_b.delete();
        pops = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(first + 8'(i * 8'h11));
    endtask

    initial begin
        // rst_n flush ready | inc vld chk_dat dat bytes
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 3'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 3'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 3'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 3'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'd0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00A3_A2A1, 3'd3};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00A3_A2A1, 3'd3};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'd0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'd0};

        R_RST_N   = 1'b0;
        FLUSH     = 1'b1;
        OUT_READY = 1'b1;
        fq.push_back(8'hA1);
        fq.push_back(8'hA2);
        fq.push_back(8'hA3);
        step();

        // Reset state, partial flush of A1..A3, then an ignored empty flush.
        for (int i = 0; i < 9; i++) begin
            R_RST_N   = tbl[i].rst_n;
            FLUSH     = tbl[i].flush;
            OUT_READY = tbl[i].ready;
            drive_fifo();
            #1;
            chk($sformatf("tbl%0d_inc", i), {31'b0, R_INC_EN}, {31'b0, tbl[i].inc});
            chk($sformatf("tbl%0d_valid", i), {31'b0, OUT_VALID}, {31'b0, tbl[i].vld});
            if (tbl[i].chk_dat) begin
                chk($sformatf("tbl%0d_data", i), OUT_DATA, tbl[i].dat);
                chk($sformatf("tbl%0d_bytes", i), {29'b0, OUT_BYTES}, {29'b0, tbl[i].bytes});
            end
            step();
        end
        FLUSH = 1'b0;

        // Streaming with OUT_READY high.
        do_reset();
        push_seq(8'h11, 8);
        run(8);
        chk("stream_pops", pops, 8);
        run(2);
        chk("stream_words", got_d.size(), 2);
        if (got_d.size() == 2) begin
            chk("stream_w0", got_d[0], 32'h4433_2211);
            chk("stream_w1", got_d[1], 32'h8877_6655);
            chk("stream_b0", {29'b0, got_b[0]}, 32'd4);
            chk("stream_b1", {29'b0, got_b[1]}, 32'd4);
        end

        // Backpressure: seven pops, then stall with word 1 held.
        do_reset();
        push_seq(8'h11, 8);
        OUT_READY = 1'b0;
        run(12);
        chk("bp_pops", pops, 7);
        #1;
        chk("bp_inc_stalled", {31'b0, R_INC_EN}, 32'd0);
        chk("bp_held_valid", {31'b0, OUT_VALID}, 32'd1);
        chk("bp_held_data", OUT_DATA, 32'h4433_2211);
        OUT_READY = 1'b1;
        run(6);
        chk("bp_pops_final", pops, 8);
        chk("bp_words", got_d.size(), 2);
        if (got_d.size() == 2) chk("bp_w1", got_d[1], 32'h8877_6655);

        // Flush coincident with a pop while the output word is stalled.
        do_reset();
        for (int i = 0; i < 4; i++) fq.push_back(8'hE1 + 8'(i));
        fq.push_back(8'hB1);
        fq.push_back(8'hB2);
        fq.push_back(8'hB3);
        OUT_READY = 1'b0;
        run(5);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        run(4);
        chk("fs_pops_stalled", pops, 6);
        chk("fs_held_data", OUT_DATA, 32'hE4E3_E2E1);
        OUT_READY = 1'b1;
        run(3);
        chk("fs_words", got_d.size(), 2);
        if (got_d.size() == 2) begin
            chk("fs_w0", got_d[0], 32'hE4E3_E2E1);
            chk("fs_w1", got_d[1], 32'h0000_B2B1);
            chk("fs_b1", {29'b0, got_b[1]}, 32'd2);
        end

        // Reset mid-word discards C1, C2.
        do_reset();
        fq.push_back(8'hC1);
        fq.push_back(8'hC2);
        run(2);
        R_RST_N = 1'b0;
        step();
        R_RST_N = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(8'hD1 + 8'(i));
        run(6);
        chk("rst_words", got_d.size(), 1);
        if (got_d.size() == 1) begin
            chk("rst_w0", got_d[0], 32'hD4D3_D2D1);
            chk("rst_b0", {29'b0, got_b[0]}, 32'd4);
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0 && fq.size() < 16) fq.push_back(8'($urandom));
            OUT_READY = ($urandom_range(0, 3) != 0);
            FLUSH     = ($urandom_range(0, 9) == 0);
            R_RST_N   = ($urandom_range(0, 499) != 0);
            step();
        end
        R_RST_N = 1'b1;
        FLUSH   = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
